// File: rtl/serial_pkg.sv
// Shared serial-subsystem definitions.
// Holds the stepped-sine level codes, the default receive thresholds, the
// baud-mode encoding and the phase-index-to-level mapping.
package serial_pkg;

    localparam logic [1:0] LVL_0 = 2'b00;
    localparam logic [1:0] LVL_1 = 2'b01;
    localparam logic [1:0] LVL_2 = 2'b10;
    localparam logic [1:0] LVL_3 = 2'b11;

    localparam int BURST0_AT_DEF    = 8;
    localparam int LONG_GAP_DEF     = 176;
    localparam int HT_THRESHOLD_DEF = 445;

    typedef enum logic {
        BAUD_1200 = 1'b0,
        BAUD_300  = 1'b1
    } baud_mode_e;

    // One tone cycle is eight phase steps: rise over 0..3, fall over 4..7.
    function automatic logic [1:0] sine_level(input logic [2:0] idx);
        logic [1:0] lvl;
        case (idx)
            3'd0, 3'd7: lvl = LVL_0;
            3'd1, 3'd6: lvl = LVL_1;
            3'd2, 3'd5: lvl = LVL_2;
            default:    lvl = LVL_3;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/cas_edge_filter.sv
// Input conditioner for an asynchronous serial line.
// Two-flop synchroniser followed by a glitch filter: the filtered level only
// follows the synchronised input after FILTER_LEN consecutive differing
// samples, and each accepted change yields a pulse that lasts one sample.
//   clk    in   master clock
//   rst_n  in   asynchronous active-low reset
//   se_i   in   sample enable
//   raw_i  in   raw asynchronous input
//   edge_o out  accepted-edge pulse, seen by exactly one sample-enable cycle
module cas_edge_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic se_i,
    input  logic raw_i,
    output logic edge_o
);

    localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

    logic       sync1_q, sync2_q;
    logic       filt_q;
    logic       edge_q;
    logic [3:0] fcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            edge_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            if (se_i) begin
                edge_q <= 1'b0;
                if (sync2_q != filt_q) begin
                    if (fcnt_q == CNT_LAST) begin
                        filt_q <= sync2_q;
                        edge_q <= 1'b1;
                        fcnt_q <= '0;
                    end else begin
                        fcnt_q <= fcnt_q + 4'd1;
                    end
                end else begin
                    fcnt_q <= '0;
                end
            end
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/cassette_fsk_codec.sv
// Cassette FSK modem.
// Transmit: a free-running phase counter drives a 4-level stepped sine, one
// low-tone cycle (txd=0) or two high-tone cycles (txd=1) per 1200-baud unit;
// in 300-baud mode a bit spans four units. Receive: edge gaps on the filtered
// cassette input generate rxc bursts and the rxd decision; a sustained rxd=1
// raises dcd.
//   clk            in   master clock
//   nRST           in   asynchronous active-low reset
//   mode_300       in   1 = 300 baud, 0 = 1200 baud
//   reverse_tones  in   inverts tone/data sense on transmit and receive
//   tx_enable      in   tone enable, sampled at bit boundaries
//   txd            in   transmit bit, sampled at bit boundaries
//   tx_bit_strobe  out  high on the last cycle of each transmit bit
//   sine_out       out  ladder level code
//   cas_in         in   raw cassette comparator input
//   rxc            out  recovered receive clock
//   rxd            out  recovered data
//   dcd            out  high-tone carrier detect
module cassette_fsk_codec
    import serial_pkg::*;
#(
    parameter int DIV_W        = 10,
    parameter int GAP_W        = 8,
    parameter int FILTER_LEN   = 4,
    parameter int BURST0_AT    = BURST0_AT_DEF,
    parameter int LONG_GAP     = LONG_GAP_DEF,
    parameter int HT_THRESHOLD = HT_THRESHOLD_DEF
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       mode_300,
    input  logic       reverse_tones,
    input  logic       tx_enable,
    input  logic       txd,
    output logic       tx_bit_strobe,
    output logic [1:0] sine_out,
    input  logic       cas_in,
    output logic       rxc,
    output logic       rxd,
    output logic       dcd
);

    localparam logic [GAP_W-1:0] GAP_B0   = GAP_W'(BURST0_AT);
    localparam logic [GAP_W-1:0] GAP_LONG = GAP_W'(LONG_GAP);
    localparam logic [8:0]       HT_TC    = 9'(HT_THRESHOLD);

    logic [DIV_W-1:0] ph_q, ph_d;
    logic [1:0]       sub_q, sub_d;
    baud_mode_e       mode_q, mode_d;
    logic             strobe_q, strobe_d;
    logic             txd_s_q, txd_s_d, en_s_q, en_s_d;
    logic [1:0]       sine_q, sine_d;
    logic [7:0]       tck_q, tck_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [2:0]       burst_q, burst_d;
    logic             rxc_q, rxc_d;
    logic             is_long_q, is_long_d, is_long_last_q, is_long_last_d;
    logic             rxd_q, rxd_d;
    logic [8:0]       ht_q, ht_d;
    logic             dcd_q, dcd_d;

    logic       ph_wrap, se, tick, cas_edge;
    logic [2:0] idx;

    cas_edge_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk   (clk),
        .rst_n (nRST),
        .se_i  (se),
        .raw_i (cas_in),
        .edge_o(cas_edge)
    );

    assign ph_wrap = &ph_q;
    assign se      = ph_q[0];
    // tck_q runs in step with the low byte of ph and keeps the 256-clk tick
    // independent of DIV_W.
    assign tick    = &tck_q;
    assign idx     = txd_s_q ? ph_q[DIV_W-2 -: 3] : ph_q[DIV_W-1 -: 3];

    always_comb begin
        ph_d           = ph_q + 1'b1;
        sub_d          = sub_q + {1'b0, ph_wrap};
        tck_d          = tck_q + 8'd1;
        // Mode only switches at a sub wrap so a 300-baud bit always starts on
        // a unit boundary; a mid-bit change just shifts the bit alignment.
        mode_d         = (ph_wrap && sub_q == 2'd3) ? baud_mode_e'(mode_300) : mode_q;
        // Strobe is registered: predict whether the next cycle ends a bit.
        strobe_d       = (&ph_d) && (mode_d == BAUD_1200 || sub_d == 2'd3);
        txd_s_d        = strobe_q ? (txd ^ reverse_tones) : txd_s_q;
        en_s_d         = strobe_q ? tx_enable : en_s_q;
        sine_d         = en_s_q ? sine_level(idx) : LVL_0;

        gap_d          = gap_q;
        burst_d        = burst_q;
        is_long_d      = is_long_q;
        is_long_last_d = is_long_last_q;
        rxd_d          = rxd_q;
        ht_d           = ht_q;
        dcd_d          = dcd_q;

        if (se) begin
            if (cas_edge)
                gap_d = '0;
            else if (gap_q != '1)
                gap_d = gap_q + 1'b1;

            // A running burst finishes untouched; an edge on the terminal
            // count sample takes priority over starting one.
            if (burst_q != 3'd0)
                burst_d = burst_q + 3'd1;
            else if (!cas_edge && (gap_q == GAP_B0 || gap_q == GAP_LONG))
                burst_d = 3'd1;

            if (cas_edge) begin
                is_long_d      = 1'b0;
                is_long_last_d = is_long_q;
                if (is_long_q)
                    rxd_d = reverse_tones;
                else if (!is_long_last_q)
                    rxd_d = !reverse_tones;
            end else if (gap_q == GAP_LONG) begin
                is_long_d = 1'b1;
            end
        end

        if (tick) begin
            if (!rxd_q) begin
                ht_d  = '0;
                dcd_d = 1'b0;
            end else begin
                if (ht_q != 9'h1FF)
                    ht_d = ht_q + 9'd1;
                if (ht_q == HT_TC)
                    dcd_d = 1'b1;
            end
        end

        // rxc is decoded from the next burst value so the clock leaves a flop.
        rxc_d = (burst_d != 3'd0) ? !burst_d[0] : 1'b1;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ph_q           <= '0;
            sub_q          <= '0;
            tck_q          <= '0;
            mode_q         <= BAUD_1200;
            strobe_q       <= 1'b0;
            txd_s_q        <= 1'b0;
            en_s_q         <= 1'b0;
            sine_q         <= LVL_0;
            gap_q          <= '0;
            burst_q        <= '0;
            rxc_q          <= 1'b1;
            is_long_q      <= 1'b0;
            is_long_last_q <= 1'b0;
            rxd_q          <= 1'b1;
            ht_q           <= '0;
            dcd_q          <= 1'b0;
        end else begin
            ph_q           <= ph_d;
            sub_q          <= sub_d;
            tck_q          <= tck_d;
            mode_q         <= mode_d;
            strobe_q       <= strobe_d;
            txd_s_q        <= txd_s_d;
            en_s_q         <= en_s_d;
            sine_q         <= sine_d;
            gap_q          <= gap_d;
            burst_q        <= burst_d;
            rxc_q          <= rxc_d;
            is_long_q      <= is_long_d;
            is_long_last_q <= is_long_last_d;
            rxd_q          <= rxd_d;
            ht_q           <= ht_d;
            dcd_q          <= dcd_d;
        end
    end

    assign tx_bit_strobe = strobe_q;
    assign sine_out      = sine_q;
    assign rxc           = rxc_q;
    assign rxd           = rxd_q;
    assign dcd           = dcd_q;

endmodule

// File: tb/tb_cassette_fsk_codec.sv
// Self-checking bench for cassette_fsk_codec (DIV_W=10, FILTER_LEN=4,
// LONG_GAP=176, HT_THRESHOLD reduced to 20 to keep the carrier test short).
module tb_cassette_fsk_codec;

    localparam int HT_TB       = 20;
    localparam int LONG_GAP_TB = 176;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       mode_300 = 1'b0;
    logic       reverse_tones = 1'b0;
    logic       tx_enable = 1'b0;
    logic       txd = 1'b0;
    logic       cas_in = 1'b0;
    logic       tx_bit_strobe, rxc, rxd, dcd;
    logic [1:0] sine_out;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;
    int exp_q[$];

    logic [1:0] lvl_tab [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};

    cassette_fsk_codec #(.HT_THRESHOLD(HT_TB)) dut (
        .clk          (clk),
        .nRST         (nRST),
        .mode_300     (mode_300),
        .reverse_tones(reverse_tones),
        .tx_enable    (tx_enable),
        .txd          (txd),
        .tx_bit_strobe(tx_bit_strobe),
        .sine_out     (sine_out),
        .cas_in       (cas_in),
        .rxc          (rxc),
        .rxd          (rxd),
        .dcd          (dcd)
    );

    always #5 clk = ~clk;

    // cyc equals the DUT phase counter value while sampled on negedges.
    always @(posedge clk or negedge nRST)
        if (!nRST) cyc <= 0;
        else       cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input logic m, input logic rv, input logic en, input logic d);
        @(negedge clk);
        nRST = 1'b0;
        mode_300 = m; reverse_tones = rv; tx_enable = en; txd = d; cas_in = 1'b0;
        repeat (3) @(negedge clk);
        nRST = 1'b1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        nRST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mode_300 = 1'($urandom); reverse_tones = 1'($urandom);
            tx_enable = 1'($urandom); txd = 1'($urandom); cas_in = 1'($urandom);
            @(negedge clk);
        end
        n_checks++; if (sine_out !== 2'b00) $display("FAIL reset_sine: got %0d want 0", sine_out); else n_pass++;
        n_checks++; if (rxc !== 1'b1) $display("FAIL reset_rxc: got %b want 1", rxc); else n_pass++;
        n_checks++; if (rxd !== 1'b1) $display("FAIL reset_rxd: got %b want 1", rxd); else n_pass++;
        n_checks++; if (dcd !== 1'b0) $display("FAIL reset_dcd: got %b want 0", dcd); else n_pass++;
        n_checks++; if (tx_bit_strobe !== 1'b0) $display("FAIL reset_strobe: got %b want 0", tx_bit_strobe); else n_pass++;
        mode_300 = 1'b0; reverse_tones = 1'b0; tx_enable = 1'b0; txd = 1'b0; cas_in = 1'b0;
        nRST = 1'b1;
        wait_cyc(1022);
        n_checks++; if (tx_bit_strobe !== 1'b0) $display("FAIL first_strobe_early: got %b want 0 at 1022", tx_bit_strobe); else n_pass++;
        wait_cyc(1023);
        n_checks++; if (tx_bit_strobe !== 1'b1) $display("FAIL first_strobe: got %b want 1 at 1023", tx_bit_strobe); else n_pass++;
        wait_cyc(1024);
        n_checks++; if (tx_bit_strobe !== 1'b0) $display("FAIL strobe_width: got %b want 0 at 1024", tx_bit_strobe); else n_pass++;
    endtask

    task automatic test_tx_1200;
        int e;
        do_reset(1'b0, 1'b0, 1'b1, 1'b0);
        wait_cyc(500);
        n_checks++; if (sine_out !== 2'b00) $display("FAIL tx_before_latch: got %0d want 0", sine_out); else n_pass++;
        for (int s = 0; s < 8; s++) begin
            exp_q.push_back(int'(lvl_tab[s]));
            wait_cyc(1024 + 128*s + 64);
            e = exp_q.pop_front();
            n_checks++;
            if (sine_out !== 2'(e)) $display("FAIL tx_low_step%0d: got %0d want %0d", s, sine_out, e);
            else n_pass++;
            if (s == 3) txd = 1'b1;
        end
        wait_cyc(2047);
        n_checks++; if (tx_bit_strobe !== 1'b1) $display("FAIL tx_strobe_2047: got %b want 1", tx_bit_strobe); else n_pass++;
        for (int s = 0; s < 16; s++) begin
            exp_q.push_back(int'(lvl_tab[s % 8]));
            wait_cyc(2048 + 64*s + 32);
            e = exp_q.pop_front();
            n_checks++;
            if (sine_out !== 2'(e)) $display("FAIL tx_high_step%0d: got %0d want %0d", s, sine_out, e);
            else n_pass++;
        end
    endtask

    task automatic count_rises(input int start, output int cnt);
        logic [1:0] prev;
        cnt = 0;
        wait_cyc(start);
        prev = sine_out;
        for (int k = start + 1; k <= start + 4096; k++) begin
            wait_cyc(k);
            if (prev == 2'b00 && sine_out == 2'b01) cnt++;
            prev = sine_out;
        end
    endtask

    task automatic test_tx_300;
        int cnt, e;
        do_reset(1'b1, 1'b0, 1'b1, 1'b1);
        wait_cyc(4095);
        n_checks++; if (tx_bit_strobe !== 1'b1) $display("FAIL tx300_strobe_4095: got %b want 1", tx_bit_strobe); else n_pass++;
        wait_cyc(5119);
        n_checks++; if (tx_bit_strobe !== 1'b0) $display("FAIL tx300_no_strobe_5119: got %b want 0", tx_bit_strobe); else n_pass++;
        wait_cyc(7167);
        n_checks++; if (tx_bit_strobe !== 1'b0) $display("FAIL tx300_no_strobe_7167: got %b want 0", tx_bit_strobe); else n_pass++;
        wait_cyc(8191);
        n_checks++; if (tx_bit_strobe !== 1'b1) $display("FAIL tx300_strobe_8191: got %b want 1", tx_bit_strobe); else n_pass++;
        exp_q.push_back(8);
        count_rises(8192, cnt);
        e = exp_q.pop_front();
        n_checks++; if (cnt !== e) $display("FAIL tx300_high_cycles: got %0d want %0d", cnt, e); else n_pass++;
        reverse_tones = 1'b1;
        wait_cyc(12287 + 4096);
        n_checks++; if (tx_bit_strobe !== 1'b1) $display("FAIL tx300_strobe_16383: got %b want 1", tx_bit_strobe); else n_pass++;
        exp_q.push_back(4);
        count_rises(16384, cnt);
        e = exp_q.pop_front();
        n_checks++; if (cnt !== e) $display("FAIL tx300_low_cycles_rev: got %0d want %0d", cnt, e); else n_pass++;
    endtask

    task automatic test_rx_loopback(input logic rv);
        int   gaps [7] = '{150, 150, 150, 300, 150, 150, 150};
        logic il, ill, r, prev;
        int   falls, e, t0, len;
        do_reset(1'b0, rv, 1'b0, 1'b0);
        wait_cyc(700);
        // Gap-level model: the idle period before the first edge counts as long.
        il = 1'b1; ill = 1'b0; r = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (il) r = rv;
            else if (!ill) r = !rv;
            ill = il;
            il  = 1'b0;
            exp_q.push_back(int'(r));
            if (i < 7) begin
                il = (gaps[i] > LONG_GAP_TB);
                exp_q.push_back(il ? 8 : 4);
            end
            cas_in = ~cas_in;
            t0 = cyc; falls = 0; prev = rxc;
            len = (i < 7) ? 2*gaps[i] : 60;
            for (int k = 1; k <= len; k++) begin
                wait_cyc(t0 + k);
                if (prev && !rxc) falls++;
                prev = rxc;
                if (k == 60) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (rxd !== 1'(e)) $display("FAIL rx_rev%0d_rxd_edge%0d: got %b want %0d", rv, i, rxd, e);
                    else n_pass++;
                end
            end
            if (i < 7) begin
                e = exp_q.pop_front();
                n_checks++;
                if (falls !== e) $display("FAIL rx_rev%0d_rxc_pulses_gap%0d: got %0d want %0d", rv, i, falls, e);
                else n_pass++;
            end
        end
    endtask

    task automatic watch_window(output int falls);
        logic prev;
        int   t0;
        falls = 0; t0 = cyc; prev = rxc;
        for (int k = 1; k <= 200; k++) begin
            wait_cyc(t0 + k);
            if (prev && !rxc) falls++;
            prev = rxc;
        end
    endtask

    task automatic test_glitch;
        int falls, e;
        do_reset(1'b0, 1'b0, 1'b0, 1'b0);
        wait_cyc(700);
        exp_q.push_back(1); exp_q.push_back(0);
        cas_in = 1'b1;
        repeat (6) @(negedge clk);
        cas_in = 1'b0;
        watch_window(falls);
        e = exp_q.pop_front();
        n_checks++; if (rxd !== 1'(e)) $display("FAIL glitch3_rxd: got %b want %0d", rxd, e); else n_pass++;
        e = exp_q.pop_front();
        n_checks++; if (falls !== e) $display("FAIL glitch3_rxc_pulses: got %0d want %0d", falls, e); else n_pass++;
        exp_q.push_back(0); exp_q.push_back(4);
        cas_in = 1'b1;
        repeat (8) @(negedge clk);
        cas_in = 1'b0;
        watch_window(falls);
        e = exp_q.pop_front();
        n_checks++; if (rxd !== 1'(e)) $display("FAIL pulse4_rxd: got %b want %0d", rxd, e); else n_pass++;
        e = exp_q.pop_front();
        n_checks++; if (falls !== e) $display("FAIL pulse4_rxc_pulses: got %0d want %0d", falls, e); else n_pass++;
    endtask

    task automatic test_dcd;
        int   r, c;
        logic found;
        do_reset(1'b0, 1'b0, 1'b0, 1'b0);
        wait_cyc(256*(HT_TB+1) - 1);
        n_checks++; if (dcd !== 1'b0) $display("FAIL dcd_before_tc: got %b want 0", dcd); else n_pass++;
        wait_cyc(256*(HT_TB+1));
        n_checks++; if (dcd !== 1'b1) $display("FAIL dcd_rise: got %b want 1", dcd); else n_pass++;
        wait_cyc(256*(HT_TB+1) + 24);
        cas_in = 1'b1;
        found = 1'b0; r = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (rxd === 1'b0) begin found = 1'b1; r = cyc; end
        end
        n_checks++;
        if (!found) $display("FAIL dcd_rxd_fall_timeout: got rxd %b want 0 within 200 clk", rxd);
        else n_pass++;
        if (found) begin
            c = r;
            while (c % 256 != 255) c++;
            wait_cyc(c);
            n_checks++; if (dcd !== 1'b1) $display("FAIL dcd_hold_before_tick: got %b want 1", dcd); else n_pass++;
            wait_cyc(c + 1);
            n_checks++; if (dcd !== 1'b0) $display("FAIL dcd_fall_at_tick: got %b want 0", dcd); else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        do_reset(1'b0, 1'b0, 1'b1, 1'b0);
        wait_cyc(1024 + 128*3 + 64);
        n_checks++; if (sine_out !== 2'b11) $display("FAIL mid_pre_reset_sine: got %0d want 3", sine_out); else n_pass++;
        #1;
        nRST = 1'b0;
        #1;
        n_checks++; if (sine_out !== 2'b00) $display("FAIL mid_reset_sine: got %0d want 0", sine_out); else n_pass++;
        n_checks++; if (rxc !== 1'b1) $display("FAIL mid_reset_rxc: got %b want 1", rxc); else n_pass++;
        @(negedge clk);
        nRST = 1'b1;
    endtask

    initial begin
        test_reset();
        test_tx_1200();
        test_tx_300();
        test_rx_loopback(1'b0);
        test_rx_loopback(1'b1);
        test_glitch();
        test_dcd();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
